// File: rtl/equation.sv
// Registered unsigned adder: z = x + y with one-cycle latency and a valid flag.
// The sum register holds its value between accepted inputs.
module equation (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] x,
  input  logic [3:0] y,
  input  logic       in_valid,
  output logic [4:0] z,
  output logic       out_valid
);

  logic [4:0] w_sum;
  logic [4:0] r_z;
  logic       r_out_valid;

  // Both operands zero-extended to 5 bits, so 3 + 15 = 18 always fits.
  always_comb begin
    w_sum = {3'b000, x} + {1'b0, y};
  end

  // Capture the sum on accepted inputs; the valid flag follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z         <= 5'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_z <= w_sum;
      end else begin
        r_z <= r_z;
      end
    end
  end

  assign z         = r_z;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_equation.sv
// Directed self-checking bench for the equation registered adder.
module tb_equation;

  logic       clk;
  logic       rst_n;
  logic [1:0] x;
  logic [3:0] y;
  logic       in_valid;
  logic [4:0] z;
  logic       out_valid;

  int total;
  int bad;

  equation dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x),
    .y        (y),
    .in_valid (in_valid),
    .z        (z),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n    = 1'b0;
    x        = 2'd3;
    y        = 4'd15;
    in_valid = 1'b1;
    #1;
    total++;
    if (z !== 5'd0) begin
      bad++;
      $display("FAIL reset_z: got %0d want 0", z);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    // A clock edge while reset is held must capture nothing.
    @(posedge clk);
    #1;
    total++;
    if (z !== 5'd0) begin
      bad++;
      $display("FAIL reset_edge_z: got %0d want 0", z);
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_edge_valid: got %b want 0", out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_max();
    @(negedge clk);
    x = 2'b11; y = 4'b1111; in_valid = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (z !== 5'd18 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL max_sum: got z=%0d v=%b want z=18 v=1", z, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (z !== 5'd18 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL max_hold: got z=%0d v=%b want z=18 v=0", z, out_valid);
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    x = 2'b00; y = 4'b0000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (z !== 5'd0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL zero_sum: got z=%0d v=%b want z=0 v=1", z, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] xs [3];
    logic [3:0] ys [3];
    logic [4:0] exp_z [3];
    xs = '{2'd1, 2'd2, 2'd3};
    ys = '{4'd4, 4'd9, 4'd0};
    exp_z = '{5'd5, 5'd11, 5'd3};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      x = xs[i]; y = ys[i]; in_valid = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (z !== exp_z[i]) begin
        bad++;
        $display("FAIL b2b_z[%0d]: got %0d want %0d", i, z, exp_z[i]);
      end
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_hold();
    // z is 3 from the previous test; toggling operands must not disturb it.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      x = 2'($urandom_range(0, 3));
      y = 4'($urandom_range(0, 15));
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if (z !== 5'd3) begin
        bad++;
        $display("FAIL hold_z[%0d]: got %0d want 3", i, z);
      end
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL hold_valid[%0d]: got %b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    x = 2'd3; y = 4'd15; in_valid = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (z !== 5'd18 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL midrst_accept: got z=%0d v=%b want z=18 v=1", z, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    total++;
    if (z !== 5'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async: got z=%0d v=%b want z=0 v=0", z, out_valid);
    end
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (z !== 5'd0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_after[%0d]: got z=%0d v=%b want z=0 v=0", i, z, out_valid);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_max();
    test_zero();
    test_back_to_back();
    test_hold();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
